// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: condition codes, PSR bit positions
// and instruction field bounds.
package fetch_unit_pkg;

    localparam int ADDRWIDTH_DEFAULT = 16;

    // PSR flag positions within psr[4:0] = {N,Z,F,L,C}
    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    // Instruction field bounds
    localparam int COND_HI = 11;
    localparam int COND_LO = 8;
    localparam int DISP_HI = 7;
    localparam int DISP_LO = 0;
    localparam int DISP_W  = DISP_HI - DISP_LO + 1;
    localparam int RTGT_HI = 3;
    localparam int RTGT_LO = 0;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0,
        CC_NE = 4'h1,
        CC_CS = 4'h2,
        CC_CC = 4'h3,
        CC_HI = 4'h4,
        CC_LS = 4'h5,
        CC_GT = 4'h6,
        CC_LE = 4'h7,
        CC_FS = 4'h8,
        CC_FC = 4'h9,
        CC_LO = 4'hA,
        CC_HS = 4'hB,
        CC_LT = 4'hC,
        CC_GE = 4'hD,
        CC_UC = 4'hE,
        CC_NV = 4'hF
    } cond_e;

endpackage

// File: rtl/fetch_unit_cond_eval.sv
// Combinational condition-code evaluator against the PSR flags.
module cond_eval
    import fetch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       true
);

    // Decode the 4-bit condition code into a single pass/fail bit
    always_comb begin
        true = 1'b0;
        case (cond_e'(cond))
            CC_EQ:   true = psr[PSR_Z];
            CC_NE:   true = !psr[PSR_Z];
            CC_CS:   true = psr[PSR_C];
            CC_CC:   true = !psr[PSR_C];
            CC_HI:   true = psr[PSR_L];
            CC_LS:   true = !psr[PSR_L];
            CC_GT:   true = psr[PSR_N];
            CC_LE:   true = !psr[PSR_N];
            CC_FS:   true = psr[PSR_F];
            CC_FC:   true = !psr[PSR_F];
            CC_LO:   true = !psr[PSR_L] && !psr[PSR_Z];
            CC_HS:   true = psr[PSR_L] || psr[PSR_Z];
            CC_LT:   true = !psr[PSR_N] && !psr[PSR_Z];
            CC_GE:   true = psr[PSR_N] || psr[PSR_Z];
            CC_UC:   true = 1'b1;
            default: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction register, branch/jump redirect and JAL
// return-address capture. All outputs are registered.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   ADDRWIDTH = ADDRWIDTH_DEFAULT,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_en,
    input  logic                 ir_load,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 link,
    input  logic [4:0]           psr,
    input  logic [15:0]          jtarget,
    input  logic [15:0]          rom_data,
    output logic [ADDRWIDTH-1:0] rom_addr,
    output logic [15:0]          inst,
    output logic [ADDRWIDTH-1:0] cur_pc,
    output logic [ADDRWIDTH-1:0] ra,
    output logic                 taken
);

    logic [ADDRWIDTH-1:0] pc_q;
    logic [ADDRWIDTH-1:0] cur_pc_q;
    logic [ADDRWIDTH-1:0] ra_q;
    logic [15:0]          ir_q;
    logic                 taken_q;

    logic                 cond_true;
    logic [ADDRWIDTH-1:0] disp_ext;
    logic [ADDRWIDTH-1:0] br_target;
    logic [ADDRWIDTH-1:0] jmp_target;

    cond_eval u_cond_eval (
        .cond (ir_q[COND_HI:COND_LO]),
        .psr  (psr),
        .true (cond_true)
    );

    assign disp_ext   = {{(ADDRWIDTH-DISP_W){ir_q[DISP_HI]}}, ir_q[DISP_HI:DISP_LO]};
    assign br_target  = cur_pc_q + disp_ext;
    assign jmp_target = jtarget[ADDRWIDTH-1:0];

    // PC / IR / RA update with priority jump > branch > ir_load
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            cur_pc_q <= '0;
            ir_q     <= '0;
            ra_q     <= '0;
            taken_q  <= 1'b0;
        end else if (!pc_en) begin
            taken_q  <= 1'b0;
        end else begin
            taken_q <= 1'b0;
            if (jump) begin
                if (link) begin
                    ra_q    <= pc_q;
                    pc_q    <= jmp_target;
                    taken_q <= 1'b1;
                end else if (cond_true) begin
                    pc_q    <= jmp_target;
                    taken_q <= 1'b1;
                end
            end else if (branch) begin
                if (cond_true) begin
                    pc_q    <= br_target;
                    taken_q <= 1'b1;
                end
            end else if (ir_load) begin
                ir_q     <= rom_data;
                cur_pc_q <= pc_q;
                pc_q     <= pc_q + ADDRWIDTH'(1);
            end
        end
    end

    assign rom_addr = pc_q;
    assign inst     = ir_q;
    assign cur_pc   = cur_pc_q;
    assign ra       = ra_q;
    assign taken    = taken_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors followed by a
// sweep of every condition code against several PSR patterns.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        ir_load;
    logic        branch;
    logic        jump;
    logic        link;
    logic [4:0]  psr;
    logic [15:0] jtarget;
    logic [15:0] rom_data;
    logic [15:0] rom_addr;
    logic [15:0] inst;
    logic [15:0] cur_pc;
    logic [15:0] ra;
    logic        taken;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.ADDRWIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_en    (pc_en),
        .ir_load  (ir_load),
        .branch   (branch),
        .jump     (jump),
        .link     (link),
        .psr      (psr),
        .jtarget  (jtarget),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .inst     (inst),
        .cur_pc   (cur_pc),
        .ra       (ra),
        .taken    (taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, e, l, b, j, k;
        logic [4:0]  p;
        logic [15:0] jt, rd;
        logic [15:0] e_addr, e_inst, e_cur, e_ra;
        logic        e_taken;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, e, l, b, j, k,
                                input logic [4:0] p,
                                input logic [15:0] jt, rd,
                                input logic [15:0] ea, ei, ec, er,
                                input logic et);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.b = b; v.j = j; v.k = k;
        v.p = p; v.jt = jt; v.rd = rd;
        v.e_addr = ea; v.e_inst = ei; v.e_cur = ec; v.e_ra = er; v.e_taken = et;
        return v;
    endfunction

    // Independent reference for the condition-code table
    function automatic logic cond_model(input logic [3:0] cc, input logic [4:0] p);
        logic n, z, f, l, c;
        n = p[4]; z = p[3]; f = p[2]; l = p[1]; c = p[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, e, l, b, j, k, input logic [4:0] p,
                         input logic [15:0] jt, rd);
        rst = r; pc_en = e; ir_load = l; branch = b; jump = j; link = k;
        psr = p; jtarget = jt; rom_data = rd;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_pc;
    logic        exp_tk;
    string       tag;

    initial begin
        rst = 1'b0; pc_en = 1'b0; ir_load = 1'b0; branch = 1'b0; jump = 1'b0;
        link = 1'b0; psr = '0; jtarget = '0; rom_data = '0;

        //          r e l b j k psr    jt        rd         addr      inst      cur       ra        tk
        vecs.push_back(mk(0,1,0,0,0,0,5'h00,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h5101, 16'h0001,16'h5101,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h5202, 16'h0002,16'h5202,16'h0001,16'h0000,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h5303, 16'h0003,16'h5303,16'h0002,16'h0000,0));
        vecs.push_back(mk(1,1,0,0,1,0,5'h00,16'h0010,16'h0000, 16'h0010,16'h5303,16'h0002,16'h0000,1));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'hC0FE, 16'h0011,16'hC0FE,16'h0010,16'h0000,0));
        vecs.push_back(mk(1,1,0,1,0,0,5'h08,16'h0000,16'h0000, 16'h000E,16'hC0FE,16'h0010,16'h0000,1));
        vecs.push_back(mk(1,1,0,1,0,0,5'h00,16'h0000,16'h0000, 16'h000E,16'hC0FE,16'h0010,16'h0000,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h3E00, 16'h000F,16'h3E00,16'h000E,16'h0000,0));
        vecs.push_back(mk(1,1,0,0,1,0,5'h00,16'h1234,16'h0000, 16'h1234,16'h3E00,16'h000E,16'h0000,1));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h3F00, 16'h1235,16'h3F00,16'h1234,16'h0000,0));
        vecs.push_back(mk(1,1,0,0,1,0,5'h1F,16'h5555,16'h0000, 16'h1235,16'h3F00,16'h1234,16'h0000,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h3E00, 16'h1236,16'h3E00,16'h1235,16'h0000,0));
        vecs.push_back(mk(1,1,0,0,1,0,5'h00,16'h0020,16'h0000, 16'h0020,16'h3E00,16'h1235,16'h0000,1));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h4000, 16'h0021,16'h4000,16'h0020,16'h0000,0));
        vecs.push_back(mk(1,1,0,0,1,1,5'h00,16'h0400,16'h0000, 16'h0400,16'h4000,16'h0020,16'h0021,1));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h3E00, 16'h0401,16'h3E00,16'h0400,16'h0021,0));
        vecs.push_back(mk(1,1,0,0,1,0,5'h00,16'hFFFF,16'h0000, 16'hFFFF,16'h3E00,16'h0400,16'h0021,1));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h2E80, 16'h0000,16'h2E80,16'hFFFF,16'h0021,0));
        vecs.push_back(mk(1,1,0,0,1,0,5'h00,16'h0005,16'h0000, 16'h0005,16'h2E80,16'hFFFF,16'h0021,1));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h2E80, 16'h0006,16'h2E80,16'h0005,16'h0021,0));
        vecs.push_back(mk(1,1,0,1,0,0,5'h00,16'h0000,16'h0000, 16'hFF85,16'h2E80,16'h0005,16'h0021,1));
        vecs.push_back(mk(1,1,1,1,1,0,5'h00,16'h0700,16'hAAAA, 16'h0700,16'h2E80,16'h0005,16'h0021,1));
        vecs.push_back(mk(1,1,1,1,0,0,5'h00,16'h0000,16'hBBBB, 16'hFF85,16'h2E80,16'h0005,16'h0021,1));
        vecs.push_back(mk(1,0,1,0,1,1,5'h00,16'h9999,16'hCCCC, 16'hFF85,16'h2E80,16'h0005,16'h0021,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h1234, 16'hFF86,16'h1234,16'hFF85,16'h0021,0));
        vecs.push_back(mk(0,1,0,1,0,0,5'h00,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,1,0,0,0,5'h00,16'h0000,16'h5101, 16'h0001,16'h5101,16'h0000,16'h0000,0));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].b, vecs[i].j, vecs[i].k,
                  vecs[i].p, vecs[i].jt, vecs[i].rd);
            tag = $sformatf("vec%0d", i);
            chk({tag, ".rom_addr"}, rom_addr, vecs[i].e_addr);
            chk({tag, ".inst"},     inst,     vecs[i].e_inst);
            chk({tag, ".cur_pc"},   cur_pc,   vecs[i].e_cur);
            chk({tag, ".ra"},       ra,       vecs[i].e_ra);
            chk({tag, ".taken"},    {15'd0, taken}, {15'd0, vecs[i].e_taken});
        end

        // Condition-code sweep through Jcond: each code against several PSR patterns
        drive(0,1,0,0,0,0,5'h00,16'h0000,16'h0000);
        exp_pc = 16'h0000;
        for (int unsigned c = 0; c < 16; c++) begin
            for (int unsigned pi = 0; pi < 6; pi++) begin
                logic [4:0] pat;
                logic [3:0] cc;
                cc = 4'(c);
                case (pi)
                    0: pat = 5'b00000;
                    1: pat = 5'b11111;
                    2: pat = 5'b01000;
                    3: pat = 5'b00010;
                    4: pat = 5'b10000;
                    default: pat = 5'b00101;
                endcase
                drive(1,1,1,0,0,0,5'h00,16'h0000,{4'h3, cc, 8'h00});
                exp_pc = exp_pc + 16'd1;
                drive(1,1,0,0,1,0,pat,{8'h01, 4'h0, cc},16'h0000);
                exp_tk = cond_model(cc, pat);
                if (exp_tk) exp_pc = {8'h01, 4'h0, cc};
                tag = $sformatf("cc%0h_psr%02b%03b", cc, pat[4:3], pat[2:0]);
                chk({tag, ".rom_addr"}, rom_addr, exp_pc);
                chk({tag, ".taken"}, {15'd0, taken}, {15'd0, exp_tk});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-register stage sitting directly upstream of the multicycle controller. It holds the PC, drives the instruction ROM address, latches the fetched word into the instruction register that the controller decodes, and resolves Bcond/Jcond/JAL redirects against the PSR flags. It also captures the JAL return address for the register-file write-back path.

## Interface
- `ADDRWIDTH`, 16: PC / ROM address width.
- `RESET_PC`, 16'h0000: PC value after reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `pc_en`  in  1  global enable; low freezes all state.
- `ir_load`  in  1  fetch strobe: capture `rom_data` into IR, advance PC.
- `branch`  in  1  evaluate Bcond in IR; redirect if condition true.
- `jump`  in  1  evaluate Jcond/JAL in IR; redirect if condition true (JAL: always).
- `link`  in  1  qualifies `jump` as JAL; capture return address.
- `psr`  in  5  flags {N,Z,F,L,C} at bits [4:0].
- `jtarget`  in  16  register-file read of IR[3:0] (jump target).
- `rom_data`  in  16  asynchronous ROM read of `rom_addr`.
- `rom_addr`  out  ADDRWIDTH  current PC (registered).
- `inst`  out  16  instruction register.
- `cur_pc`  out  ADDRWIDTH  address of the instruction in `inst`.
- `ra`  out  ADDRWIDTH  JAL return-address register.
- `taken`  out  1  registered; 1 for one cycle after a redirect.

## Operation
- Reset (`rst`=0 at edge): pc=RESET_PC, cur_pc=0, inst=0x0000, ra=0, taken=0. Overrides every other input.
- `pc_en`=0: pc, cur_pc, inst, ra hold; taken<=0.
- With `pc_en`=1, priority jump > branch > ir_load; lower-priority strobes in the same cycle are ignored.
- ir_load: inst<=rom_data; cur_pc<=pc; pc<=pc+1.
- branch: cond=inst[11:8], disp=inst[7:0] signed. If true: pc<=cur_pc+sext(disp), taken<=1. If false: pc unchanged, taken<=0.
- jump, link=0 (Jcond): cond=inst[11:8]. If true: pc<=jtarget, taken<=1.
- jump, link=1 (JAL): unconditional; ra<=pc (already next address); pc<=jtarget; taken<=1.
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E UC 1; F never.
- Arithmetic modulo 2^ADDRWIDTH: pc 0xFFFF+1 wraps to 0x0000; branch targets wrap both directions.
- `taken` cleared in every enabled cycle without a successful redirect.

## Timing
- rom_addr, inst, cur_pc, ra, taken all register outputs; no combinational input-to-output paths.
- Fetch latency: ir_load in cycle N, inst valid from cycle N+1 (controller DECODE).
- Redirect: strobe in cycle N, new rom_addr in N+1; next ir_load may occur in N+1.
- psr and jtarget sampled in the strobe cycle only.
- Reset mid-sequence (e.g. between ir_load and branch) discards everything; first fetch after reset reads RESET_PC.

## Structure
- defines.v gains: condition-code constants (`EQ`..`NV`), PSR bit indices (`PSR_N`..`PSR_C`), instruction field bounds for cond/disp/Rtarget, `ADDRWIDTH`.
- Sub-module `cond_eval`: combinational, inputs cond[3:0] and psr[4:0], output `true`; reused by Scond later.

## Test plan
- Reset then three ir_load with ROM 0x0000→0x5101, 0x0001→0x5202, 0x0002→0x5303 -> inst sequence 0x5101/0x5202/0x5303, cur_pc 0/1/2, rom_addr 3.
- IR=0xC0FE at cur_pc=0x0010, Z=1, branch -> rom_addr 0x000E, taken=1 one cycle; same with Z=0 -> rom_addr unchanged, taken=0.
- IR Jcond cond=E, jtarget=0x1234 -> rom_addr 0x1234; cond=F -> no redirect.
- JAL at cur_pc=0x0020 (pc 0x0021), jtarget=0x0400 -> ra=0x0021, rom_addr=0x0400, taken=1.
- pc=0xFFFF, ir_load -> rom_addr 0x0000; branch disp 0x80 at cur_pc=0x0005 -> 0xFF85.
- jump+branch+ir_load same cycle -> only jump effect; pc_en=0 with strobes -> all state held; rst=0 mid-run -> all outputs to reset values next edge.
